ser_frame_arb: RTL and testbench

Round-robin arbiter and sequencer for a shared 8-bit serial-to-parallel capture buffer. Two bit-serial sources request the buffer. The block grants one source at a time, shifts in exactly one 8-bit frame MSB-first, then presents the byte on a valid/ready parallel port. It sits between the serial front-end sources and the byte-wide consumer, replacing free-running shift capture with explicit framing and sharing.

---
 rtl/ser_frame_arb_if.sv | 23 ++
 rtl/ser_frame_arb.sv | 115 +++++++++++
 tb/tb_ser_frame_arb.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ser_frame_arb_if.sv
// Bus bundle for ser_frame_arb: per-source request/serial lines plus the byte-wide valid/ready port.
// The arbiter takes the slave view; sources and consumer (or a bench) take the master view.
interface ser_frame_arb_if;
  logic [1:0] req;
  logic [1:0] sdin;
  logic [1:0] gnt;
  logic [7:0] dout;
  logic       dout_vld;
  logic       dout_rdy;
  logic       dout_src;
  logic       dout_perr;
  logic       busy;

  modport master (
    output req, sdin, dout_rdy,
    input  gnt, dout, dout_vld, dout_src, dout_perr, busy
  );

  modport slave (
    input  req, sdin, dout_rdy,
    output gnt, dout, dout_vld, dout_src, dout_perr, busy
  );
endinterface

// File: rtl/ser_frame_arb.sv
// Round-robin arbiter that shifts one 8-bit MSB-first frame from one of two serial sources
// into a byte presented on a valid/ready port. Optional even-parity bit: define SER_PARITY_EN.
module ser_frame_arb (
  input logic            clk,
  input logic            rst,
  ser_frame_arb_if.slave bus
);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
`endif

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] shreg;
  logic       sel;
  logic       last_src;
  logic [1:0] gnt;
  logic [7:0] dout;
  logic       vld;
  logic       src;
  logic       busy;
  logic       pick;
  logic       sbit;

  assign sbit = bus.sdin[sel];

  // On a tie the source not served last wins; a lone request always wins.
  always_comb begin
    pick = 1'b0;
    if (bus.req == 2'b11) pick = ~last_src;
    else                  pick = bus.req[1];
  end

`ifdef SER_PARITY_EN
  logic perr;
  assign bus.dout_perr = perr;
`else
  assign bus.dout_perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      shreg    <= 8'h00;
      sel      <= 1'b0;
      last_src <= 1'b1;
      gnt      <= 2'b00;
      dout     <= 8'h00;
      vld      <= 1'b0;
      src      <= 1'b0;
      busy     <= 1'b0;
`ifdef SER_PARITY_EN
      perr     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            sel      <= pick;
            last_src <= pick;
            gnt      <= pick ? 2'b10 : 2'b01;
            cnt      <= 4'd0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          shreg <= {shreg[6:0], sbit};
          cnt   <= cnt + 4'd1;
          if (cnt == 4'd7) begin
`ifdef SER_PARITY_EN
            state <= PAR;
`else
            gnt   <= 2'b00;
            dout  <= {shreg[6:0], sbit};
            src   <= sel;
            vld   <= 1'b1;
            state <= HOLD;
`endif
          end
        end
`ifdef SER_PARITY_EN
        // shreg now holds the full data byte; the grant stays up one more cycle for the parity bit.
        PAR: begin
          gnt   <= 2'b00;
          dout  <= shreg;
          perr  <= ^{shreg, sbit};
          src   <= sel;
          vld   <= 1'b1;
          state <= HOLD;
        end
`endif
        HOLD: begin
          if (bus.dout_rdy) begin
            vld   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt;
  assign bus.dout     = dout;
  assign bus.dout_vld = vld;
  assign bus.dout_src = src;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_ser_frame_arb.sv
// Randomized self-checking bench for ser_frame_arb; the frame-level reference model tracks
// the round-robin pointer, the last delivered byte and the expected parity flag.
module tb_ser_frame_arb;
  logic clk = 1'b0;
  logic rst;

  ser_frame_arb_if bus ();

  ser_frame_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic       last_m;
  logic [7:0] dout_m;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then let the edge pass and settle before sampling.
  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] s, input logic rdy);
    bus.req      = r;
    bus.sdin     = s;
    bus.dout_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] onehot(input logic i);
    return i ? 2'b10 : 2'b01;
  endfunction

  function automatic logic expect_pick(input logic [1:0] r);
    if (r == 2'b01) return 1'b0;
    if (r == 2'b10) return 1'b1;
    return (last_m == 1'b0) ? 1'b1 : 1'b0;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_gnt"},  32'(bus.gnt),       32'h0);
    checkOutput({tag, "_dout"}, 32'(bus.dout),      32'h0);
    checkOutput({tag, "_vld"},  32'(bus.dout_vld),  32'h0);
    checkOutput({tag, "_busy"}, 32'(bus.busy),      32'h0);
    checkOutput({tag, "_src"},  32'(bus.dout_src),  32'h0);
    checkOutput({tag, "_perr"}, 32'(bus.dout_perr), 32'h0);
  endtask

  // One full frame from request to handshake; optionally aborted by reset after 5 bits.
  task automatic runFrame(input logic [1:0] r, input logic [7:0] data, input logic pbit,
                          input int stall, input bit midreset);
    logic       s;
    logic [1:0] sd;
    logic       exp_perr;
    s = expect_pick(r);
    applyStimulus(r, 2'($urandom), 1'($urandom));
    last_m = s;
    checkOutput("grant",     32'(bus.gnt),      32'(onehot(s)));
    checkOutput("busy_on",   32'(bus.busy),     32'h1);
    checkOutput("dout_keep", 32'(bus.dout),     32'(dout_m));
    checkOutput("vld_idle",  32'(bus.dout_vld), 32'h0);
    for (int i = 7; i >= 0; i--) begin
      sd    = 2'($urandom);
      sd[s] = data[i];
      if (midreset && i == 2) begin
        rst = 1'b1;
        applyStimulus(2'($urandom), sd, 1'b1);
        rst = 1'b0;
        checkResetOutputs("midrst");
        last_m = 1'b1;
        dout_m = 8'h00;
        return;
      end
      applyStimulus(2'($urandom), sd, 1'($urandom));
      if (i > 0 || PAR_EN) begin
        checkOutput("gnt_hold",  32'(bus.gnt),      32'(onehot(s)));
        checkOutput("vld_shift", 32'(bus.dout_vld), 32'h0);
      end
    end
    if (PAR_EN) begin
      sd    = 2'($urandom);
      sd[s] = pbit;
      applyStimulus(2'($urandom), sd, 1'($urandom));
    end
    exp_perr = PAR_EN ? ((^data) ^ pbit) : 1'b0;
    checkOutput("vld_up",  32'(bus.dout_vld),  32'h1);
    checkOutput("dout",    32'(bus.dout),      32'(data));
    checkOutput("src",     32'(bus.dout_src),  32'(s));
    checkOutput("perr",    32'(bus.dout_perr), 32'(exp_perr));
    checkOutput("gnt_off", 32'(bus.gnt),       32'h0);
    checkOutput("busy_hold", 32'(bus.busy),    32'h1);
    dout_m = data;
    for (int k = 0; k < stall; k++) begin
      applyStimulus(2'($urandom), 2'($urandom), 1'b0);
      checkOutput("stall_vld",  32'(bus.dout_vld), 32'h1);
      checkOutput("stall_dout", 32'(bus.dout),     32'(data));
      checkOutput("stall_gnt",  32'(bus.gnt),      32'h0);
    end
    applyStimulus(2'($urandom), 2'($urandom), 1'b1);
    checkOutput("vld_drop",  32'(bus.dout_vld), 32'h0);
    checkOutput("busy_off",  32'(bus.busy),     32'h0);
    checkOutput("dout_ret",  32'(bus.dout),     32'(data));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] r;
    rst          = 1'b1;
    bus.req      = 2'b00;
    bus.sdin     = 2'b00;
    bus.dout_rdy = 1'b0;
    applyStimulus(2'b11, 2'b11, 1'b1);
    applyStimulus(2'b11, 2'b11, 1'b1);
    checkResetOutputs("reset");
    rst    = 1'b0;
    last_m = 1'b1;
    dout_m = 8'h00;

    applyStimulus(2'b00, 2'($urandom), 1'b1);
    checkOutput("idle_gnt",  32'(bus.gnt),  32'h0);
    checkOutput("idle_busy", 32'(bus.busy), 32'h0);

    runFrame(2'b01, 8'hA5, 1'b0, 0, 1'b0);
    for (int n = 0; n < 3; n++) runFrame(2'b11, 8'($urandom), 1'($urandom), 0, 1'b0);
    runFrame(2'b10, 8'h3C, 1'b0, 5, 1'b0);
    runFrame(2'b01, 8'($urandom), 1'b0, 0, 1'b1);
    runFrame(2'b11, 8'($urandom), 1'($urandom), 0, 1'b0);
    runFrame(2'b01, 8'hFF, 1'b0, 1, 1'b0);
    runFrame(2'b10, 8'h01, 1'b0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int idle;
      idle = int'($urandom_range(0, 2));
      for (int k = 0; k < idle; k++) begin
        applyStimulus(2'b00, 2'($urandom), 1'($urandom));
        checkOutput("gap_gnt", 32'(bus.gnt),      32'h0);
        checkOutput("gap_vld", 32'(bus.dout_vld), 32'h0);
      end
      r = 2'($urandom_range(1, 3));
      runFrame(r, 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
